// File: rtl/clock_divider_prog.sv
// ============================================================================
// clock_divider_prog
// ----------------------------------------------------------------------------
// Runtime-programmable clock divider and strobe generator. It supplies the
// spectrum analyzer's audio sample-rate and display-refresh timing.
//
// The divided clock is low for low_act cycles and then high for
// (div_act - low_act) cycles. A one-cycle tick marks each completed period.
// New divisor/low-phase settings arrive through a valid/ready handshake. They
// are held in a shadow register and move into the active registers only at a
// period boundary, so the output never shows a runt pulse.
//
// Optional feature (compile-time macro CLKDIV_SYNC_EN):
//   This macro adds the sync_in port. A sync_in pulse restarts the period at
//   phase 0 on the next edge, whatever the value of enable. It also applies
//   any pending configuration. Use it to phase-align several dividers.
//
// Parameters:
//   WIDTH      width of the counter, divisor and low-count registers
//   DIVISOR    divisor active after reset       (2 .. 2^WIDTH-1)
//   LOW_COUNT  low-phase length after reset     (1 .. DIVISOR-1)
//
// Ports:
//   clock_in    in   system clock; all state changes on its rising edge
//   reset       in   synchronous, active-high reset
//   enable      in   1 = count, 0 = freeze counter and outputs
//   sync_in     in   (CLKDIV_SYNC_EN only) phase restart pulse
//   div_in      in   requested divisor
//   low_in      in   requested low-phase cycle count
//   load_valid  in   request to load div_in/low_in
//   load_ready  out  block can accept a load (FSM idle)
//   clock_out   out  divided clock (registered)
//   tick        out  one-cycle pulse per completed period (registered)
//   cfg_err     out  sticky: the most recent load was illegal
//   pending     out  legal load captured, waiting for a period boundary
// ============================================================================
module clock_divider_prog #(
    parameter int unsigned WIDTH     = 32'd28,
    parameter int unsigned DIVISOR   = 32'd1133,
    parameter int unsigned LOW_COUNT = DIVISOR / 32'd2
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             enable,
`ifdef CLKDIV_SYNC_EN
    input  logic             sync_in,
`endif
    input  logic [WIDTH-1:0] div_in,
    input  logic [WIDTH-1:0] low_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             clock_out,
    output logic             tick,
    output logic             cfg_err,
    output logic             pending
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DIVISOR);
    localparam logic [WIDTH-1:0] LOW_RST = WIDTH'(LOW_COUNT);
    localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] TWO     = {{(WIDTH-2){1'b0}}, 2'b10};

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_PEND = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Helper: a configuration is usable only if the period has a non-empty
    // low phase and a non-empty high phase.
    // ------------------------------------------------------------------------
    function automatic logic cfg_legal(input logic [WIDTH-1:0] div_v,
                                       input logic [WIDTH-1:0] low_v);
        cfg_legal = (div_v >= TWO) && (low_v >= ONE) && (low_v < div_v);
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t           state_r;
    logic [WIDTH-1:0] counter_r;
    logic [WIDTH-1:0] div_act_r;
    logic [WIDTH-1:0] low_act_r;
    logic [WIDTH-1:0] div_sh_r;
    logic [WIDTH-1:0] low_sh_r;
    logic             clock_out_r;
    logic             tick_r;
    logic             cfg_err_r;
    logic             pending_r;
    logic             load_ready_r;

    // ------------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------------
    logic             sync_s;
    logic             wrap_s;
    logic             transfer_s;
    logic             legal_s;
    logic             apply_s;
    logic [WIDTH-1:0] counter_nx_s;
    logic             clock_nx_s;
    logic             tick_nx_s;

`ifdef CLKDIV_SYNC_EN
    assign sync_s = sync_in;
`else
    assign sync_s = 1'b0;
`endif

    // Period boundary, handshake acceptance and shadow-apply decode.
    always_comb begin
        wrap_s     = enable && (counter_r == (div_act_r - ONE));
        transfer_s = load_valid && (state_r == S_IDLE);
        legal_s    = cfg_legal(div_in, low_in);
        // A pending config goes live at the next wrap. It goes live at once
        // when the divider is frozen, because a frozen divider would
        // otherwise never reach a boundary. A sync restart also applies it.
        apply_s    = (state_r == S_PEND) && (wrap_s || !enable || sync_s);
    end

    // Next counter / clock_out / tick values.
    always_comb begin
        counter_nx_s = counter_r;
        clock_nx_s   = clock_out_r;
        tick_nx_s    = 1'b0;
        if (sync_s) begin
            // Forced restart: the truncated period gets no tick.
            counter_nx_s = ZERO;
            clock_nx_s   = 1'b0;
            tick_nx_s    = 1'b0;
        end else if (enable) begin
            if (wrap_s) begin
                counter_nx_s = ZERO;
            end else begin
                counter_nx_s = counter_r + ONE;
            end
            // clock_out is derived from the value the counter is about to
            // take, so the registered output lines up with the counter.
            // After a wrap the next value is 0, which lies below any legal
            // low count, old or new. Comparing against the current low_act
            // therefore stays correct at an apply boundary.
            clock_nx_s = (counter_nx_s >= low_act_r);
            tick_nx_s  = wrap_s;
        end else if (apply_s) begin
            // Frozen with a pending config: start the new config at phase 0.
            counter_nx_s = ZERO;
            clock_nx_s   = 1'b0;
            tick_nx_s    = 1'b0;
        end else begin
            // Frozen: hold counter and clock_out; tick stays low.
            counter_nx_s = counter_r;
            clock_nx_s   = clock_out_r;
            tick_nx_s    = 1'b0;
        end
    end

    // Counter, output registers and active configuration.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            counter_r   <= ZERO;
            clock_out_r <= 1'b0;
            tick_r      <= 1'b0;
            div_act_r   <= DIV_RST;
            low_act_r   <= LOW_RST;
        end else begin
            counter_r   <= counter_nx_s;
            clock_out_r <= clock_nx_s;
            tick_r      <= tick_nx_s;
            if (apply_s) begin
                div_act_r <= div_sh_r;
                low_act_r <= low_sh_r;
            end else begin
                div_act_r <= div_act_r;
                low_act_r <= low_act_r;
            end
        end
    end

    // Load-handshake FSM with its registered status outputs and shadow regs.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_r      <= S_IDLE;
            div_sh_r     <= DIV_RST;
            low_sh_r     <= LOW_RST;
            cfg_err_r    <= 1'b0;
            pending_r    <= 1'b0;
            load_ready_r <= 1'b1;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (transfer_s && legal_s) begin
                        div_sh_r     <= div_in;
                        low_sh_r     <= low_in;
                        cfg_err_r    <= 1'b0;
                        state_r      <= S_PEND;
                        pending_r    <= 1'b1;
                        load_ready_r <= 1'b0;
                    end else if (transfer_s) begin
                        // Rejected: the active and shadow configs are kept.
                        cfg_err_r    <= 1'b1;
                        pending_r    <= 1'b0;
                        load_ready_r <= 1'b1;
                    end else begin
                        pending_r    <= 1'b0;
                        load_ready_r <= 1'b1;
                    end
                end
                S_PEND: begin
                    // load_valid is not accepted here; the master holds it.
                    if (apply_s) begin
                        state_r      <= S_IDLE;
                        pending_r    <= 1'b0;
                        load_ready_r <= 1'b1;
                    end else begin
                        pending_r    <= 1'b1;
                        load_ready_r <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= S_IDLE;
                    pending_r    <= 1'b0;
                    load_ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign load_ready = load_ready_r;
    assign clock_out  = clock_out_r;
    assign tick       = tick_r;
    assign cfg_err    = cfg_err_r;
    assign pending    = pending_r;

endmodule

// File: doc/clock_divider_prog.md
Name: clock_divider_prog

Overview:
- Runtime-programmable clock divider and strobe generator for the spectrum analyzer's audio sample-rate and display-refresh timing.
- Divides `clock_in` by a divisor with a programmable low-phase length.
- Emits a divided square wave plus a one-cycle tick strobe per period.
- New divisor/duty settings are loaded through a valid/ready handshake and applied glitch-free at the next period boundary.

Parameters:
- WIDTH, 28, width of counter, divisor and low-count registers.
- DIVISOR, 1133, divisor active after reset; legal range 2..2^WIDTH-1.
- LOW_COUNT, DIVISOR/2, low-phase cycles active after reset; legal range 1..DIVISOR-1.

Ports:
- clock_in  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = count; 0 = freeze counter and outputs.
- div_in  in  WIDTH  requested divisor.
- low_in  in  WIDTH  requested low-phase cycle count.
- load_valid  in  1  request to load div_in/low_in.
- load_ready  out  1  block can accept a load.
- clock_out  out  1  divided clock: low for low_act cycles, then high for div_act-low_act cycles.
- tick  out  1  one-cycle pulse per completed period.
- cfg_err  out  1  sticky flag: last load was illegal.
- pending  out  1  legal load captured but not yet applied.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Registers: counter; div_act/low_act (active); div_sh/low_sh (shadow); 2-state FSM IDLE/PEND.
- Reset values:
  - counter=0, div_act=DIVISOR, low_act=LOW_COUNT, FSM=IDLE.
  - clock_out=0, tick=0, cfg_err=0, pending=0, load_ready=1.
- Reset mid-period or mid-handshake drops any shadowed config and restarts at counter=0 with defaults.
- Wrap condition: wrap = enable && counter==div_act-1.
- Counting (enable=1): counter <= wrap ? 0 : counter+1. Arithmetic is unsigned WIDTH-bit; counter never exceeds div_act-1.
- enable=0: counter, clock_out and tick hold their values; tick is forced 0.
- clock_out is registered from the next counter value:
  - clock_out <= (next_counter >= low_act), so it is aligned with counter in the same cycle.
  - No combinational path from counter to the output pin.
- tick <= wrap. tick is high in the cycle counter reads 0 after a wrap.
- Handshake:
  - load_ready = (FSM==IDLE). A transfer occurs when load_valid && load_ready.
  - Legal means div_in>=2 && low_in>=1 && low_in<div_in.
  - Legal transfer: div_sh/low_sh captured, cfg_err <= 0, FSM -> PEND, pending=1.
  - Illegal transfer: nothing captured, cfg_err <= 1, FSM stays IDLE, active config unchanged.
  - load_valid while PEND is ignored (not accepted); the master must hold it.
- Apply (PEND):
  - On wrap: div_act/low_act <= shadow, counter <= 0, FSM -> IDLE. The next period uses the new config.
  - If enable=0 while PEND: apply on the next cycle, counter <= 0, clock_out <= 0.
- Simultaneous events:
  - A transfer in the same cycle as a wrap is not applied at that wrap; it is applied at the following wrap.
  - reset overrides all other inputs.

Optional Feature:
- Macro: CLKDIV_SYNC_EN.
- When defined:
  - Adds input `sync_in` (1 bit).
  - A sync_in pulse forces counter <= 0 and clock_out <= 0 on the next edge, regardless of enable. This phase-aligns multiple dividers.
  - If PEND, the shadow config is applied at the same time.
  - tick is not asserted for a sync-truncated period.
- When undefined: the port and its logic are absent; behaviour is exactly as above.

Test Plan:
- Reset, enable=1, defaults -> clock_out low 566 cycles then high 567 cycles; tick every 1133 cycles; load_ready=1.
- Load div_in=10, low_in=3 at counter=200 -> pending=1 and load_ready=0 until the wrap at counter=1132; then 10-cycle periods with 3 low and 7 high; pending=0.
- Load div_in=1, low_in=0 -> cfg_err=1, load_ready stays 1, period stays 1133. A later legal load of 8/4 clears cfg_err.
- enable=0 for 50 cycles at counter=300 -> counter, clock_out and tick frozen; the period resumes and the next tick comes 833 enabled cycles later.
- Load 10/3 in the same cycle as a wrap -> the current 1133 period runs fully; the new config starts at the following wrap. Assert reset while PEND -> defaults restored and pending=0.
- With CLKDIV_SYNC_EN defined, sync_in pulse at counter=700 -> counter=0 and clock_out=0 next cycle; no tick issued; normal periods follow.
